mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 10, word-index width; memory depth 2^ADDR_BITS 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted before each response; legal range 0..15.
REQ-003 clk  input  1  single clock, rising edge active.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 address  input  32  byte address from CPU memory mux; always word-aligned for legal traffic.
REQ-006 read  input  1  read request.
REQ-007 write  input  1  write request.
REQ-008 byteenable  input  4  byte-lane enables; bit i selects writedata[8i+7:8i].
REQ-009 writedata  input  32  write data.
REQ-010 waitrequest  output  1  high = request not yet accepted; initiator holds all inputs stable.
REQ-011 readdata  output  32  read data, valid in the cycle waitrequest is low for a read.
REQ-012 error  output  1  protocol-error flag (see Configuration).

Function
REQ-013 States: IDLE, BUSY, RESP; waitrequest SHALL be low only in RESP, high in IDLE and BUSY.
REQ-014 IDLE: request (read|write) present -> BUSY with down-counter loaded to WAIT_CYCLES-1; if WAIT_CYCLES=0 -> RESP directly.
REQ-015 BUSY: counter decrements each cycle; counter=0 -> RESP.
REQ-016 RESP: transfer completes at the rising edge ending this cycle; next state IDLE unconditionally (one idle cycle between back-to-back transfers).
REQ-017 Latency: request first sampled at cycle N -> waitrequest low at cycle N+WAIT_CYCLES+1.
REQ-018 Word index = address[ADDR_BITS+1:2]; higher bits ignored (address wraps modulo depth); address[1:0] ignored for indexing.
REQ-019 Write: at end of RESP, byte lane i of the indexed word updated iff byteenable[i]=1; other lanes unchanged; byteenable=0000 writes nothing.
REQ-020 Read: readdata registered on entry to RESP with the full 32-bit indexed word regardless of byteenable; lane extraction is the CPU's job.
REQ-021 readdata SHALL hold its last value outside RESP and across writes.
REQ-022 read and write both high: treated as write; readdata unchanged.
REQ-023 Request deasserted in BUSY or RESP (protocol violation): return to IDLE next edge, no memory write performed.
REQ-024 Read of a word written in the immediately preceding transfer SHALL return the new data (no bypass hazard, since one IDLE cycle separates transfers).

Reset
REQ-025 reset_n low: state IDLE, counter 0, waitrequest 1, readdata 0x00000000, error 0, asynchronously and independent of clk.
REQ-026 Memory contents SHALL NOT be reset; contents after power-up are undefined.
REQ-027 Reset asserted mid-transfer aborts it; a write in RESP is not performed if reset_n is low at that edge.
REQ-028 Reset deasserted with a request present: request sampled at the first rising edge with reset_n high.

Configuration
REQ-029 Macro MEM_RESPONDER_CHECK_EN defined: error set (sticky until reset) when a request is sampled in IDLE with address[1:0]!=00, with read&write both high, or with byteenable not in {0001,0010,0100,1000,1100,0011,1111}; transfer still completes per REQ-018..REQ-022.
REQ-030 Macro undefined: error tied to 0, no checking logic synthesized.

Verification
REQ-031 WAIT_CYCLES=2: write 0xDEADBEEF to 0x00000010 with byteenable 1111 -> waitrequest high 3 cycles, low 1 cycle; subsequent read of 0x10 -> readdata 0xDEADBEEF.
REQ-032 Word 0x10 = 0xDEADBEEF, write 0x000000AA with byteenable 0001, then 0x0000CC00 with 0010 -> read returns 0xDEADCCAA.
REQ-033 ADDR_BITS=10: write 0x11111111 to 0x00001004 -> read of 0x00000004 returns 0x11111111 (wrap).
REQ-034 WAIT_CYCLES=0: back-to-back reads -> waitrequest pattern 1,0,1,0; readdata valid on each low cycle.
REQ-035 reset_n pulsed low during BUSY of a write to 0x20 (old 0x12345678) -> waitrequest 1, readdata 0, later read of 0x20 returns 0x12345678.
REQ-036 MEM_RESPONDER_CHECK_EN defined: read at 0x00000003 -> error rises after the request is sampled and stays 1 until reset_n low; undefined -> error stays 0.

Source files
------------

// File: rtl/mem_responder.sv
// Wait-state memory slave: IDLE -> BUSY (WAIT_CYCLES) -> RESP, byte-lane writes, registered reads.
// Optional protocol checking enabled by defining MEM_RESPONDER_CHECK_EN.
module mem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e                 state_q;
  logic [3:0]             cnt_q;
  logic [31:0]            readdata_q;
  logic [31:0]            mem_q [2**ADDR_BITS];
  logic                   req;
  logic                   loadRead;
  logic [ADDR_BITS-1:0]   idx;
  logic [31:0]            readdata_d;
  logic                   unused_addr;

  assign req         = read | write;
  assign loadRead    = read & ~write;
  assign idx         = address[ADDR_BITS+1:2];
  assign readdata_d  = mem_q[idx];
  assign unused_addr = ^{address[31:ADDR_BITS+2], address[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      readdata_q <= 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (WAIT_CYCLES == 0) begin
              state_q <= RESP;
              if (loadRead) readdata_q <= readdata_d;
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        BUSY: begin
          // A dropped request is a protocol violation: abandon the transfer.
          if (!req) begin
            state_q <= IDLE;
          end else if (cnt_q == 4'd0) begin
            state_q <= RESP;
            if (loadRead) readdata_q <= readdata_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Contents are intentionally not reset; reset forces IDLE so no write can land.
  always_ff @(posedge clk) begin
    if (state_q == RESP && write) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) mem_q[idx][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

`ifdef MEM_RESPONDER_CHECK_EN
  logic error_q;
  logic beLegal;

  always_comb begin
    beLegal = 1'b0;
    case (byteenable)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b1100, 4'b0011, 4'b1111: beLegal = 1'b1;
      default:                   beLegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error_q <= 1'b0;
    end else if (state_q == IDLE && req &&
                 (address[1:0] != 2'b00 || (read && write) || !beLegal)) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign waitrequest = (state_q != RESP);
  assign readdata    = readdata_q;

endmodule
